fpga_top: RTL and testbench
===========================

# fpga_top

Board-level top for the serial bring-up image. It sends a fixed 4-byte banner over an 8N1 UART TX pin after reset and resends it on demand. It receives 8N1 UART on an RX pin, optionally echoing bytes back. It holds the SPI and I2C header pins in safe idle states and drives three status pins.

## Interface
- BAUD_DIV, 10417: clock cycles per UART bit (100 MHz / 9600 bps).
- HB_BIT, 25: heartbeat toggles when free-running counter bit HB_BIT toggles.
- CLK100MHZ in 1: 100 MHz clock. Single clock domain; the only clock.
- nrst in 1: reset. Synchronous, active-high despite the codebase name; sampled on CLK100MHZ rising edge.
- ck_io0 out 1: SPI SCLK, constant 0.
- ck_io1 in 1: banner-resend request, active-low, asynchronous.
- ck_io2 out 1: SPI MOSI, constant 0.
- ck_io3 out 1: SPI CS_n, constant 1.
- ck_io4 out 1: tx_busy, 1 while any TX frame is in progress.
- ck_io5 out 1: sticky RX framing error.
- ck_io6 out 1: heartbeat.
- ck_io7 out 1: UART TX, idle high.
- ck_io8 in 1: UART RX, idle high, asynchronous.
- ck_io38, ck_io39 inout 1: I2C SCL/SDA. Always high-Z; inputs are ignored.

## Operation
- Reset values:
  - ck_io7=1, ck_io4=0, ck_io5=0, ck_io6=0.
  - ck_io0=0, ck_io2=0, ck_io3=1.
  - All counters 0.
  - Banner request is set, so the banner always follows reset.
- Banner ROM: 0x4F, 0x4B, 0x0D, 0x0A ("OK\r\n"). Bytes are sent in order, back-to-back, with no idle gap between frames.
- TX frame:
  - Start bit 0, then 8 data bits LSB first, then 1 stop bit 1.
  - Each bit lasts exactly BAUD_DIV cycles, so one frame is 10·BAUD_DIV cycles.
- TX arbiter states:
  - IDLE → BANNER when a banner is requested.
  - IDLE → ECHO when the echo register is full (ECHO_EN only).
  - BANNER → IDLE after the 4th stop bit.
  - ECHO → IDLE after its stop bit.
  - When both requests are pending, the banner has priority.
- ck_io1 handling:
  - Passed through a 2-flop synchronizer, then edge-detected.
  - A 1→0 edge sets the banner request.
  - If a banner is already in progress, the request is kept and the banner runs again once afterwards. Further edges are merged into that single pending request.
- RX path:
  - ck_io8 is 2-flop synchronized.
  - A falling edge in idle starts a frame.
  - The start bit is re-checked at BAUD_DIV/2. If the line is high, the frame is aborted as a glitch.
  - Data bits are sampled every BAUD_DIV cycles thereafter, LSB first.
  - The stop bit is sampled at its mid-point. Stop=0 sets ck_io5 sticky until reset, and the byte is discarded.
- ck_io6 equals bit HB_BIT of a free-running 32-bit cycle counter.
- Reset asserted mid-frame:
  - TX is forced high immediately on the next edge.
  - The RX frame is dropped.
  - The banner restarts from byte 0 after release.

## Timing
- First start bit: ck_io7 goes low on the first rising edge after nrst is sampled 0 following reset.
- Banner duration: 40·BAUD_DIV cycles.
- ck_io4 is high from the start-bit edge until the end of the last stop bit of the current TX activity.
- A received byte is valid at its stop-bit mid-point. With ECHO_EN, its echo start bit begins within 2 cycles of that point if TX is idle.
- ck_io1 falling to banner start: 3–4 cycles when TX is idle.

## Configuration
- FPGA_TOP_ECHO_EN defined:
  - Each good RX byte is written to a 1-entry echo register.
  - A new byte overwrites an unsent one (latest wins).
  - The register is transmitted in state ECHO.
- Undefined:
  - The RX path and ck_io5 still operate.
  - No echo register exists; the ECHO state is absent.

## Structure
- Package fpga_top_pkg holds:
  - the banner ROM constant and the BANNER_LEN=4 constant;
  - the TX-arbiter state enum (IDLE, BANNER, ECHO).
- One sub-module, uart_tx_8n1:
  - byte in with a start strobe;
  - busy out;
  - BAUD_DIV parameter.
- The RX receiver, synchronizers, arbiter and heartbeat are inline in fpga_top.

## Test plan
- Reset release with ck_io8=1 and ck_io1=1:
  - ck_io7 carries 0x4F, 0x4B, 0x0D, 0x0A, each bit 10417 cycles.
  - ck_io4 is high for exactly 416,680 cycles.
  - ck_io7 then stays 1.
- Static pins during and after reset: ck_io0=0, ck_io2=0, ck_io3=1, and ck_io38/39 read high-Z (pulled 1 by the bench).
- Drive ck_io1 low mid-banner: the banner completes, then a second "OK\r\n" follows immediately. A second low pulse during the same banner adds no third banner.
- Send 0x5A on ck_io8 at 9600 bps, ECHO_EN defined: after the banner, ck_io7 emits 0x5A. ck_io5 stays 0.
- Send a frame with stop bit 0: ck_io5=1 until the next reset, and no echo is sent.
- Assert nrst mid-banner for 5 cycles: ck_io7=1 the next edge, and after release the banner restarts from 0x4F.

Source files
------------

// File: rtl/fpga_top_pkg.sv
// rtl/fpga_top_pkg.sv - shared constants and TX arbiter state type for fpga_top
package fpga_top_pkg;

  localparam int BANNER_LEN = 4;
  // "OK\r\n", byte 0 in the low octet
  localparam logic [BANNER_LEN*8-1:0] BANNER_ROM = {8'h0A, 8'h0D, 8'h4B, 8'h4F};

  typedef enum logic [1:0] {
    IDLE,
    BANNER,
    ECHO
  } tx_state_t;

  function automatic logic [7:0] banner_byte(input logic [1:0] idx);
    return BANNER_ROM[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/fpga_top_if.sv
// rtl/fpga_top_if.sv - byte stream handshake between the TX arbiter and the UART transmitter
interface fpga_top_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/uart_tx_8n1.sv
// rtl/uart_tx_8n1.sv - 8N1 UART transmitter; accepts the next byte in the last stop-bit cycle
module uart_tx_8n1 #(
  parameter int BAUD_DIV = 10417
) (
  input  logic      i_clk,
  input  logic      i_rst,
  fpga_top_if.slave s_tx,
  output logic      o_busy,
  output logic      o_tx
);
  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] BAUD_MAX = CW'(BAUD_DIV - 1);

  logic          r_busy;
  logic          r_tx;
  logic [CW-1:0] r_baud_cnt;
  logic [3:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          w_last;

  // bit 0 is the start bit, 1..8 data, 9 the stop bit
  assign w_last      = r_busy && (r_baud_cnt == BAUD_MAX) && (r_bit_idx == 4'd9);
  assign s_tx.tready = ~r_busy | w_last;
  assign o_busy      = r_busy;
  assign o_tx        = r_tx;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy     <= 1'b0;
      r_tx       <= 1'b1;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
    end else if (s_tx.tvalid && s_tx.tready) begin
      r_busy     <= 1'b1;
      r_tx       <= 1'b0;
      r_shift    <= s_tx.tdata;
      r_bit_idx  <= '0;
      r_baud_cnt <= '0;
    end else if (r_busy) begin
      if (r_baud_cnt != BAUD_MAX) begin
        r_baud_cnt <= r_baud_cnt + CW'(1);
      end else begin
        r_baud_cnt <= '0;
        if (r_bit_idx == 4'd9) begin
          r_busy <= 1'b0;
          r_tx   <= 1'b1;
        end else begin
          r_bit_idx <= r_bit_idx + 4'd1;
          r_tx      <= (r_bit_idx == 4'd8) ? 1'b1 : r_shift[0];
          r_shift   <= {1'b0, r_shift[7:1]};
        end
      end
    end
  end

endmodule

// File: rtl/fpga_top.sv
// rtl/fpga_top.sv - serial bring-up top: banner TX, 8N1 RX, optional echo under FPGA_TOP_ECHO_EN
module fpga_top
  import fpga_top_pkg::*;
#(
  parameter int BAUD_DIV = 10417,
  parameter int HB_BIT   = 25
) (
  input  logic CLK100MHZ,
  input  logic nrst,
  output logic ck_io0,
  input  logic ck_io1,
  output logic ck_io2,
  output logic ck_io3,
  output logic ck_io4,
  output logic ck_io5,
  output logic ck_io6,
  output logic ck_io7,
  input  logic ck_io8,
  inout  wire  ck_io38,
  inout  wire  ck_io39
);
  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] FULL_MAX = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_MAX = CW'(BAUD_DIV / 2 - 1);

  logic          r_io1_s1, r_io1_s2, r_io1_prev;
  logic          r_rx_s1, r_rx_s2, r_rx_prev;
  logic [31:0]   r_hb_cnt;
  logic          r_rx_active, r_rx_done, r_rx_ferr;
  logic [CW-1:0] r_rx_cnt;
  logic [3:0]    r_rx_bit;
  logic [7:0]    r_rx_shift;
  tx_state_t     r_state;
  logic [2:0]    r_byte_idx;
  logic          r_banner_req;

  logic          w_io1_fall, w_hs, w_cont_banner, w_new_banner, w_new_echo;
  logic          w_tvalid, w_echo_full, w_tx_busy, w_tx_line;
  logic [7:0]    w_tdata, w_echo_data;
  logic [CW-1:0] w_rx_lim;

  fpga_top_if u_tx_if ();

  always_ff @(posedge CLK100MHZ) begin
    if (nrst) begin
      {r_io1_s1, r_io1_s2, r_io1_prev} <= 3'b111;
      {r_rx_s1, r_rx_s2, r_rx_prev}    <= 3'b111;
      r_hb_cnt                         <= '0;
    end else begin
      {r_io1_prev, r_io1_s2, r_io1_s1} <= {r_io1_s2, r_io1_s1, ck_io1};
      {r_rx_prev, r_rx_s2, r_rx_s1}    <= {r_rx_s2, r_rx_s1, ck_io8};
      r_hb_cnt                         <= r_hb_cnt + 32'd1;
    end
  end

  assign w_io1_fall = r_io1_prev & ~r_io1_s2;
  assign w_rx_lim   = (r_rx_bit == 4'd0) ? HALF_MAX : FULL_MAX;

  // start bit re-checked at half a bit, later samples one full bit apart
  always_ff @(posedge CLK100MHZ) begin
    if (nrst) begin
      r_rx_active <= 1'b0;
      r_rx_done   <= 1'b0;
      r_rx_ferr   <= 1'b0;
      r_rx_cnt    <= '0;
      r_rx_bit    <= '0;
      r_rx_shift  <= '0;
    end else begin
      r_rx_done <= 1'b0;
      if (!r_rx_active) begin
        if (r_rx_prev & ~r_rx_s2) begin
          r_rx_active <= 1'b1;
          r_rx_cnt    <= '0;
          r_rx_bit    <= '0;
        end
      end else if (r_rx_cnt != w_rx_lim) begin
        r_rx_cnt <= r_rx_cnt + CW'(1);
      end else begin
        r_rx_cnt <= '0;
        if (r_rx_bit == 4'd0) begin
          if (r_rx_s2) r_rx_active <= 1'b0;
          else         r_rx_bit    <= 4'd1;
        end else if (r_rx_bit == 4'd9) begin
          r_rx_active <= 1'b0;
          if (r_rx_s2) r_rx_done <= 1'b1;
          else         r_rx_ferr <= 1'b1;
        end else begin
          r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
          r_rx_bit   <= r_rx_bit + 4'd1;
        end
      end
    end
  end

`ifdef FPGA_TOP_ECHO_EN
  logic       r_echo_full;
  logic [7:0] r_echo_data;

  always_ff @(posedge CLK100MHZ) begin
    if (nrst) begin
      r_echo_full <= 1'b0;
      r_echo_data <= '0;
    end else if (r_rx_done) begin
      r_echo_full <= 1'b1;
      r_echo_data <= r_rx_shift;
    end else if (w_hs && w_new_echo) begin
      r_echo_full <= 1'b0;
    end
  end

  assign w_echo_full = r_echo_full;
  assign w_echo_data = r_echo_data;
`else
  logic w_unused_rx;
  assign w_echo_full = 1'b0;
  assign w_echo_data = 8'h00;
  assign w_unused_rx = ^{r_rx_shift, r_rx_done};
`endif

  // next byte is offered whenever the transmitter can take it, so frames chain gap-free
  always_comb begin
    w_cont_banner = 1'b0;
    w_new_banner  = 1'b0;
    w_new_echo    = 1'b0;
    w_tvalid      = 1'b0;
    w_tdata       = banner_byte(2'd0);
    if (r_state == BANNER && r_byte_idx != 3'(BANNER_LEN)) begin
      w_cont_banner = 1'b1;
      w_tvalid      = 1'b1;
      w_tdata       = banner_byte(r_byte_idx[1:0]);
    end else if (r_banner_req) begin
      w_new_banner = 1'b1;
      w_tvalid     = 1'b1;
    end else if (w_echo_full) begin
      w_new_echo = 1'b1;
      w_tvalid   = 1'b1;
      w_tdata    = w_echo_data;
    end
  end

  assign u_tx_if.tvalid = w_tvalid;
  assign u_tx_if.tdata  = w_tdata;
  assign w_hs           = w_tvalid & u_tx_if.tready;

  always_ff @(posedge CLK100MHZ) begin
    if (nrst) begin
      r_state      <= IDLE;
      r_byte_idx   <= '0;
      r_banner_req <= 1'b1;
    end else begin
      r_banner_req <= w_io1_fall | (r_banner_req & ~(w_hs & w_new_banner));
      if (w_hs) begin
        if (w_cont_banner) begin
          r_byte_idx <= r_byte_idx + 3'd1;
        end else if (w_new_banner) begin
          r_state    <= BANNER;
          r_byte_idx <= 3'd1;
        end else begin
          r_state <= ECHO;
        end
      end else if (u_tx_if.tready) begin
        r_state <= IDLE;
      end
    end
  end

  uart_tx_8n1 #(.BAUD_DIV(BAUD_DIV)) u_tx (
    .i_clk  (CLK100MHZ),
    .i_rst  (nrst),
    .s_tx   (u_tx_if.slave),
    .o_busy (w_tx_busy),
    .o_tx   (w_tx_line)
  );

  logic w_unused_hb;
  assign w_unused_hb = ^r_hb_cnt;

  assign ck_io0  = 1'b0;
  assign ck_io2  = 1'b0;
  assign ck_io3  = 1'b1;
  assign ck_io4  = w_tx_busy;
  assign ck_io5  = r_rx_ferr;
  assign ck_io6  = r_hb_cnt[HB_BIT];
  assign ck_io7  = w_tx_line;
  assign ck_io38 = 1'bz;
  assign ck_io39 = 1'bz;

endmodule

// File: tb/tb_fpga_top.sv
// tb/tb_fpga_top.sv - self-checking bench for fpga_top with a frame-level TX model
module tb_fpga_top;
  localparam int B  = 16;
  localparam int HB = 3;

  logic clk  = 1'b0;
  logic nrst = 1'b1;
  logic io1  = 1'b1;
  logic io8  = 1'b1;
  wire  io0, io2, io3, io4, io5, io6, io7;
  wire  w_scl, w_sda;

  pullup (w_scl);
  pullup (w_sda);

  fpga_top #(.BAUD_DIV(B), .HB_BIT(HB)) dut (
    .CLK100MHZ (clk),
    .nrst      (nrst),
    .ck_io0    (io0),
    .ck_io1    (io1),
    .ck_io2    (io2),
    .ck_io3    (io3),
    .ck_io4    (io4),
    .ck_io5    (io5),
    .ck_io6    (io6),
    .ck_io7    (io7),
    .ck_io8    (io8),
    .ck_io38   (w_scl),
    .ck_io39   (w_sda)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  logic rst_smp = 1'b1;
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rst_smp <= nrst;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  bit         mon_en = 1'b0;
  bit         mon_act = 1'b0;
  int         mon_off, mk, run, last_run, last_start, nstart, rel_cyc;
  logic [7:0] mon_byte, mon_dec;
  logic       mbit;

  initial begin
    run = 0; last_run = 0; last_start = 0; nstart = 0; rel_cyc = 0; mon_off = 0;
  end

  // frame model: each expected byte becomes start, 8 data bits LSB first, stop, B cycles each
  always @(negedge clk) begin
    if (mon_en) begin
      chk1("spi_sclk", io0, 1'b0);
      chk1("spi_mosi", io2, 1'b0);
      chk1("spi_csn", io3, 1'b1);
      chk1("i2c_scl_hiz", w_scl, 1'b1);
      chk1("i2c_sda_hiz", w_sda, 1'b1);
      if (rst_smp) begin
        chk1("tx_in_reset", io7, 1'b1);
        chk1("busy_in_reset", io4, 1'b0);
        chk1("ferr_in_reset", io5, 1'b0);
        chk1("hb_in_reset", io6, 1'b0);
        mon_act = 1'b0;
        run     = 0;
      end else begin
        chk1("heartbeat", io6, 1'(((cyc - rel_cyc) >> HB) & 1));
        if (!mon_act && io7 === 1'b0) begin
          mon_act    = 1'b1;
          mon_off    = 0;
          mon_dec    = 8'h00;
          nstart++;
          last_start = cyc;
          chk("frame_expected", int'(exp_q.size() != 0), 1);
          mon_byte = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hFF;
        end
        if (mon_act) begin
          mk   = mon_off / B;
          mbit = (mk == 0) ? 1'b0 : (mk == 9) ? 1'b1 : mon_byte[mk-1];
          chk1("tx_bit", io7, mbit);
          chk1("busy_in_frame", io4, 1'b1);
          if (mon_off % B == B / 2 && mk >= 1 && mk <= 8) mon_dec[mk-1] = io7;
          mon_off++;
          if (mon_off == 10 * B) begin
            mon_act = 1'b0;
            got_q.push_back(mon_dec);
          end
        end else begin
          chk1("tx_idle", io7, 1'b1);
          chk1("busy_idle", io4, 1'b0);
        end
        if (io4 === 1'b1) run++;
        else if (run > 0) begin
          last_run = run;
          run      = 0;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push_banner();
    exp_q.push_back(8'h4F);
    exp_q.push_back(8'h4B);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic wait_quiet(input int limit);
    int t = 0;
    while ((exp_q.size() != 0 || mon_act || io4 !== 1'b0) && t < limit) begin
      step(1);
      t++;
    end
    chk("quiet_within_budget", int'(t < limit), 1);
    step(20);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop, output int stop_cyc);
    io8 = 1'b0;
    step(B);
    for (int i = 0; i < 8; i++) begin
      io8 = b[i];
      step(B);
    end
    io8      = stop;
    stop_cyc = cyc;
    step(B);
    io8 = 1'b1;
  endtask

  initial begin
    int f, s, n0;
    step(3);
    mon_en = 1'b1;
    step(3);

    // banner after reset release
    push_banner();
    rel_cyc = cyc;
    nrst    = 1'b0;
    step(9);
    chk("first_start_cycle", last_start, rel_cyc + 1);
    chk1("hb_count9", io6, 1'b1);
    step(8);
    chk1("hb_count17", io6, 1'b0);
    wait_quiet(2000);
    chk("banner_busy_len", last_run, 40 * B);
    chk("banner_frames", nstart, 4);
    chk("banner_b0", got_q[0], 8'h4F);
    chk("banner_b1", got_q[1], 8'h4B);
    chk("banner_b2", got_q[2], 8'h0D);
    chk("banner_b3", got_q[3], 8'h0A);

    // resend request from idle, then two merged requests during that banner
    push_banner();
    f   = cyc;
    io1 = 1'b0;
    step(4);
    io1 = 1'b1;
    step(2);
    chk_range("req_to_start", last_start - f, 3, 4);
    push_banner();
    step(100);
    io1 = 1'b0;
    step(4);
    io1 = 1'b1;
    step(100);
    io1 = 1'b0;
    step(4);
    io1 = 1'b1;
    wait_quiet(3000);
    chk("resend_busy_len", last_run, 80 * B);
    chk("resend_frames", nstart, 12);

    // good RX byte
    n0 = nstart;
`ifdef FPGA_TOP_ECHO_EN
    exp_q.push_back(8'h5A);
`endif
    send_rx(8'h5A, 1'b1, s);
    wait_quiet(500);
`ifdef FPGA_TOP_ECHO_EN
    chk("echo_frames", nstart, n0 + 1);
    chk_range("echo_latency", last_start - s, 0, B + 2);
    chk("echo_byte", got_q[got_q.size()-1], 8'h5A);
`else
    chk("no_echo_frames", nstart, n0);
`endif
    chk1("ferr_after_good", io5, 1'b0);

    // RX frame with stop bit 0
    n0 = nstart;
    send_rx(8'hA5, 1'b0, s);
    step(30);
    chk1("ferr_set", io5, 1'b1);
    chk("bad_no_echo", nstart, n0);
    step(50);
    chk1("ferr_sticky", io5, 1'b1);

    // reset in the middle of a banner
    push_banner();
    io1 = 1'b0;
    step(4);
    io1 = 1'b1;
    step(200);
    nrst = 1'b1;
    step(1);
    exp_q.delete();
    push_banner();
    step(4);
    chk1("ferr_cleared", io5, 1'b0);
    rel_cyc = cyc;
    nrst    = 1'b0;
    step(9);
    chk("restart_start_cycle", last_start, rel_cyc + 1);
    wait_quiet(2000);
    chk("restart_busy_len", last_run, 40 * B);
    chk("restart_b0", got_q[got_q.size()-4], 8'h4F);
    chk("restart_b3", got_q[got_q.size()-1], 8'h0A);
    chk("exp_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "cycle budget exhausted");
  end

endmodule
